// File: rtl/uart_tx_frame_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_frame_pkg
//   Shared definitions for the UART transmit path.
//   - txState_t   : transmit FSM state encoding
//   - PAR_*       : ParityType codes (bit 1 set means "no parity")
//   - FRAME_BITS  : serial frame length {stop, parity, data[7:0], start}
//   - calcParity  : parity slot value for a byte and parity selection
//   - buildFrame  : assembles the 11-bit frame, bit 0 goes on the line first
// ----------------------------------------------------------------------------
package uart_tx_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } txState_t;

    localparam logic [1:0] PAR_ODD  = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    // Any code with bit 1 set selects "none"; only bit 1 is decoded.
    localparam logic [1:0] PAR_NONE = 2'b10;

    localparam int FRAME_BITS = 11;

    // Odd parity makes the total ones count (data + parity) odd, so the
    // parity bit is the inverted XOR reduction. "None" drives the slot high
    // so the line looks like an extra stop bit.
    function automatic logic calcParity(input logic [7:0] data,
                                        input logic [1:0] parityType);
        logic par;
        if (parityType[1] == PAR_NONE[1]) begin
            par = 1'b1;
        end else if (parityType == PAR_EVEN) begin
            par = ^data;
        end else if (parityType == PAR_ODD) begin
            par = ~^data;
        end else begin
            par = 1'b1;
        end
        return par;
    endfunction

    // Bit 0 = start, bits 1-8 = data LSB first, bit 9 = parity, bit 10 = stop.
    // Matches the parallel word layout of the receive-side deframer.
    function automatic logic [FRAME_BITS-1:0] buildFrame(input logic [7:0] data,
                                                         input logic [1:0] parityType);
        return {1'b1, calcParity(data, parityType), data, 1'b0};
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// ----------------------------------------------------------------------------
// uart_baud_counter
//   Bit-period timer for the UART transmitter. Counts 0..CLKS_PER_BIT-1 and
//   flags the last cycle of each bit period.
//
//   Parameters
//     CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//   Ports
//     Clock   in  system clock, rising edge
//     Reset   in  synchronous active-high reset, counter to 0
//     Clear   in  holds the counter at 0 (used while the transmitter idles so
//                 the first bit of a frame gets a full period)
//     BitTick out high during the last cycle of a bit period; the transmitter
//                 presents the next bit on the edge that ends this cycle
// ----------------------------------------------------------------------------
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    output logic BitTick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] baudCnt;

    always_ff @(posedge Clock) begin
        if (Reset || Clear) begin
            baudCnt <= '0;
        end else if (baudCnt == LAST_CNT) begin
            baudCnt <= '0;
        end else begin
            baudCnt <= baudCnt + 1'b1;
        end
    end

    assign BitTick = (baudCnt == LAST_CNT);

endmodule

// File: rtl/uart_tx_frame.sv
// ----------------------------------------------------------------------------
// uart_tx_frame
//   UART transmitter. Accepts one byte per Send handshake while idle, builds
//   the 11-bit frame {stop, parity, data[7:0], start} and shifts it out LSB
//   first on TxOut, each bit held CLKS_PER_BIT cycles.
//
//   Parameters
//     CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//   Ports
//     Clock      in   system clock, rising edge
//     Reset      in   synchronous active-high reset; abandons any frame
//     Send       in   start request, only looked at while idle
//     DataIn     in   byte to send, captured on the accepting edge
//     ParityType in   00 odd, 01 even, 1x none (slot driven 1)
//     TxOut      out  registered serial line, idles high
//     Busy       out  high from the accepting edge to the end of the stop bit
//     Done       out  single-cycle pulse when the stop bit completes
// ----------------------------------------------------------------------------
module uart_tx_frame
    import uart_tx_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Send,
    input  logic [7:0] DataIn,
    input  logic [1:0] ParityType,
    output logic       TxOut,
    output logic       Busy,
    output logic       Done
);

    txState_t              state;
    logic [FRAME_BITS-1:0] shiftReg;
    logic [2:0]            bitIdx;
    logic                  bitTick;
    logic                  baudClear;
    logic [FRAME_BITS-1:0] loadFrame;

    // The counter sits at 0 while idle, so the accepting edge starts a
    // fresh bit period and the start bit lasts exactly CLKS_PER_BIT cycles.
    assign baudClear = (state == IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) baudCounter (
        .Clock  (Clock),
        .Reset  (Reset),
        .Clear  (baudClear),
        .BitTick(bitTick)
    );

    assign loadFrame = buildFrame(DataIn, ParityType);

    // shiftReg holds the bits not yet on the line; TxOut is the bit currently
    // being sent. Shifting in 1s means the register drains to the idle level.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            TxOut    <= 1'b1;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            bitIdx   <= 3'd0;
            shiftReg <= '1;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    TxOut <= 1'b1;
                    Busy  <= 1'b0;
                    if (Send) begin
                        TxOut    <= loadFrame[0];
                        shiftReg <= {1'b1, loadFrame[FRAME_BITS-1:1]};
                        Busy     <= 1'b1;
                        bitIdx   <= 3'd0;
                        state    <= START;
                    end
                end

                START: begin
                    if (bitTick) begin
                        TxOut    <= shiftReg[0];
                        shiftReg <= {1'b1, shiftReg[FRAME_BITS-1:1]};
                        bitIdx   <= 3'd0;
                        state    <= DATA;
                    end
                end

                DATA: begin
                    if (bitTick) begin
                        TxOut    <= shiftReg[0];
                        shiftReg <= {1'b1, shiftReg[FRAME_BITS-1:1]};
                        // 3-bit index wraps 7 -> 0 as the last data bit ends.
                        bitIdx   <= bitIdx + 3'd1;
                        if (bitIdx == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                end

                PARITY: begin
                    if (bitTick) begin
                        TxOut    <= shiftReg[0];
                        shiftReg <= {1'b1, shiftReg[FRAME_BITS-1:1]};
                        state    <= STOP;
                    end
                end

                STOP: begin
                    if (bitTick) begin
                        TxOut    <= 1'b1;
                        shiftReg <= '1;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: begin
                    TxOut    <= 1'b1;
                    Busy     <= 1'b0;
                    shiftReg <= '1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic       send;
    logic [7:0] dataIn;
    logic [1:0] parityType;
    logic       txOut;
    logic       busy;
    logic       done;

    int nChecks = 0;
    int nBad    = 0;

    uart_tx_frame #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .Clock     (clk),
        .Reset     (rst),
        .Send      (send),
        .DataIn    (dataIn),
        .ParityType(parityType),
        .TxOut     (txOut),
        .Busy      (busy),
        .Done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observe one frame starting just after its accepting edge (cycle 0)
    // through cycle 44. Optionally pulse Send with injData at injCycle.
    task automatic captureFrame(input int injCycle, input logic [7:0] injData,
                                output logic [10:0] bits, output int holdErr,
                                output int busyErr, output int doneCnt,
                                output logic doneAt44, output logic idleAt44);
        logic samp [0:44];
        holdErr  = 0;
        busyErr  = 0;
        doneCnt  = 0;
        doneAt44 = 1'b0;
        idleAt44 = 1'b0;
        for (int c = 0; c <= 44; c++) begin
            samp[c] = txOut;
            if (busy !== (c <= 43)) busyErr++;
            if (done === 1'b1) doneCnt++;
            if (c == 44) begin
                doneAt44 = done;
                idleAt44 = txOut;
            end
            if (c == injCycle) begin
                send   = 1'b1;
                dataIn = injData;
            end else if (injCycle >= 0 && c == injCycle + 1) begin
                send = 1'b0;
            end
            if (c < 44) tick();
        end
        for (int k = 0; k < 11; k++) begin
            bits[k] = samp[4*k + 2];
            for (int j = 0; j < 4; j++) begin
                if (samp[4*k + j] !== samp[4*k]) holdErr++;
            end
        end
    endtask

    task automatic checkFrame(input string tag, input logic [10:0] bits,
                              input logic [10:0] expBits, input int holdErr,
                              input int busyErr, input int doneCnt,
                              input logic doneAt44, input logic idleAt44);
        chk({tag, "_bits"}, 32'(bits), 32'(expBits));
        chk({tag, "_hold"}, holdErr, 0);
        chk({tag, "_busy"}, busyErr, 0);
        chk({tag, "_donecnt"}, doneCnt, 1);
        chk({tag, "_done44"}, 32'(doneAt44), 1);
        chk({tag, "_idle44"}, 32'(idleAt44), 1);
    endtask

    task automatic doFrame(input string tag, input logic [7:0] data,
                           input logic [1:0] ptype, input logic [10:0] expBits);
        logic [10:0] bits;
        int          holdErr, busyErr, doneCnt;
        logic        d44, i44;
        dataIn     = data;
        parityType = ptype;
        send       = 1'b1;
        tick();
        send = 1'b0;
        captureFrame(-1, 8'h00, bits, holdErr, busyErr, doneCnt, d44, i44);
        checkFrame(tag, bits, expBits, holdErr, busyErr, doneCnt, d44, i44);
        tick();
        tick();
    endtask

    initial begin
        logic [10:0] bits;
        int          holdErr, busyErr, doneCnt;
        logic        d44, i44;
        int          cntA, cntB, cntC;

        rst        = 1'b1;
        send       = 1'b1;
        dataIn     = 8'h5A;
        parityType = 2'b00;

        // 1: reset with Send asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_tx", 32'(txOut), 1);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
        end
        rst  = 1'b0;
        send = 1'b0;
        tick();
        chk("post_rst_tx", 32'(txOut), 1);
        chk("post_rst_busy", 32'(busy), 0);
        tick();

        // 2: 0xA5 odd parity -> 0,1,0,1,0,0,1,0,1,1,1
        doFrame("a5_odd", 8'hA5, 2'b00, 11'b1_1_10100101_0);

        // 3: even parity and none
        doFrame("07_even", 8'h07, 2'b01, 11'b1_1_00000111_0);
        doFrame("03_even", 8'h03, 2'b01, 11'b1_0_00000011_0);
        doFrame("03_none", 8'h03, 2'b10, 11'b1_1_00000011_0);

        // 4: Send with new data mid-frame is ignored
        dataIn     = 8'h3C;
        parityType = 2'b00;
        send       = 1'b1;
        tick();
        send = 1'b0;
        captureFrame(10, 8'hFF, bits, holdErr, busyErr, doneCnt, d44, i44);
        checkFrame("ignore", bits, 11'b1_1_00111100_0, holdErr, busyErr, doneCnt, d44, i44);
        cntA = 0;
        cntB = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy !== 1'b0) cntA++;
            if (done !== 1'b0 || txOut !== 1'b1) cntB++;
        end
        chk("ignore_nobusy", cntA, 0);
        chk("ignore_quiet", cntB, 0);

        // 5: reset in the DATA state abandons the frame
        dataIn     = 8'hC3;
        parityType = 2'b00;
        send       = 1'b1;
        tick();
        send = 1'b0;
        for (int c = 1; c <= 19; c++) tick();
        chk("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        chk("abort_tx", 32'(txOut), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        rst  = 1'b0;
        cntA = 0;
        cntB = 0;
        cntC = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done !== 1'b0) cntA++;
            if (txOut !== 1'b1) cntB++;
            if (busy !== 1'b0) cntC++;
        end
        chk("abort_nodone", cntA, 0);
        chk("abort_txidle", cntB, 0);
        chk("abort_idle", cntC, 0);
        doFrame("post_abort", 8'h81, 2'b00, 11'b1_1_10000001_0);

        // 6: Send held high -> back-to-back frames with one idle cycle
        dataIn     = 8'h55;
        parityType = 2'b00;
        send       = 1'b1;
        tick();
        dataIn = 8'hAA;
        captureFrame(-1, 8'h00, bits, holdErr, busyErr, doneCnt, d44, i44);
        checkFrame("b2b_first", bits, 11'b1_1_01010101_0, holdErr, busyErr, doneCnt, d44, i44);
        tick();
        send = 1'b0;
        chk("b2b_start_tx", 32'(txOut), 0);
        chk("b2b_start_busy", 32'(busy), 1);
        captureFrame(-1, 8'h00, bits, holdErr, busyErr, doneCnt, d44, i44);
        checkFrame("b2b_second", bits, 11'b1_1_10101010_0, holdErr, busyErr, doneCnt, d44, i44);
        tick();
        tick();
        chk("final_idle_tx", 32'(txOut), 1);
        chk("final_idle_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
